// File: rtl/ppu_line_reader.sv
// rtl/ppu_line_reader.sv - line-buffer read side: fetch, skid FIFO, horizontal pixel repeat
// Optional build macro: PPU_LINE_READER_COLORKEY_EN adds key_color/bg_color substitution.
// Ports:
//   clk, rst             clock (also the RAM rclk), asynchronous active-high reset
//   start, busy, done    line control: start pulse, line in progress, end-of-line pulse
//   raddr, read_data     RAM read port, data valid the cycle after raddr is issued
//   pix_data, pix_valid  pixel stream toward the video output stage
//   pix_ready, pix_last  downstream acceptance, final beat of the line
//   key_color, bg_color  (colour-key build only) matching head words are emitted as bg_color
module ppu_line_reader #(
  parameter int SIZE   = 8,
  parameter int DEPTH  = 256,
  parameter int HSCALE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] raddr,
  input  logic [SIZE-1:0]          read_data,
`ifdef PPU_LINE_READER_COLORKEY_EN
  input  logic [SIZE-1:0]          key_color,
  input  logic [SIZE-1:0]          bg_color,
`endif
  output logic [SIZE-1:0]          pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     pix_last,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (HSCALE > 1) ? $clog2(HSCALE) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [RW-1:0] LAST_REP  = RW'(HSCALE - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]      state;
  logic            inflight;
  logic [SIZE-1:0] fifo_mem [2];
  logic            wptr;
  logic            rptr;
  logic [1:0]      fifo_count;
  logic [RW-1:0]   rep;
  logic [AW-1:0]   word_cnt;
  logic [SIZE-1:0] head;
  logic            xfer;
  logic            pop;
  logic            push;
  logic            issue;
  logic            final_xfer;

  assign head       = fifo_mem[rptr];
  assign pix_valid  = (fifo_count != 2'd0);
  assign xfer       = pix_valid & pix_ready;
  assign pop        = xfer & (rep == LAST_REP);
  assign push       = inflight;
  // word_cnt indexes the head word within the line; raddr runs ahead of it.
  assign pix_last   = pix_valid & (rep == LAST_REP) & (word_cnt == LAST_ADDR);
  assign final_xfer = pix_last & pix_ready;
  assign busy       = (state != IDLE);

  // Credit check: queued words plus the read in flight must leave room for one
  // more, counting the slot freed by a pop this cycle. This keeps the FIFO at
  // two entries while still allowing one beat per cycle at HSCALE=1.
  assign issue = (state == FETCH) &&
                 (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  always_comb begin
    pix_data = '0;
    if (pix_valid) begin
      pix_data = head;
`ifdef PPU_LINE_READER_COLORKEY_EN
      if (head == key_color) begin
        pix_data = bg_color;
      end
`endif
    end
  end

  // Sequencer: address walk and line completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      raddr    <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            raddr <= '0;
          end
        end
        FETCH: begin
          if (issue) begin
            // Natural wrap to 0 on the last address, so raddr rests at 0 afterwards.
            raddr <= raddr + AW'(1);
            if (raddr == LAST_ADDR) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The final beat can only leave once every word was captured, so the
          // FIFO is empty and no read is in flight after this edge.
          if (final_xfer) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry skid FIFO fed by the RAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      fifo_count  <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wptr] <= read_data;
        wptr           <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 2'd1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 2'd1;
      end
    end
  end

  // Repeat counter and output word index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep      <= '0;
      word_cnt <= '0;
    end else if (xfer) begin
      if (pop) begin
        rep      <= '0;
        word_cnt <= word_cnt + AW'(1);
      end else begin
        rep <= rep + RW'(1);
      end
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count == 2'd2)));

endmodule

// File: tb/tb_ppu_line_reader.sv
// tb/tb_ppu_line_reader.sv - randomized self-checking bench for ppu_line_reader
module tb_ppu_line_reader;

  localparam int SIZE   = 8;
  localparam int DEPTH  = 8;
  localparam int HSCALE = 2;
  localparam int TOTAL  = DEPTH * HSCALE;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic [2:0]      raddr;
  logic [SIZE-1:0] read_data;
  logic [SIZE-1:0] pix_data;
  logic            pix_valid;
  logic            pix_ready;
  logic            pix_last;
  logic            done;
`ifdef PPU_LINE_READER_COLORKEY_EN
  logic [SIZE-1:0] key_color = 8'h13;
  logic [SIZE-1:0] bg_color  = 8'hAA;
`endif

  ppu_line_reader #(.SIZE(SIZE), .DEPTH(DEPTH), .HSCALE(HSCALE)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .raddr(raddr),
    .read_data(read_data),
`ifdef PPU_LINE_READER_COLORKEY_EN
    .key_color(key_color),
    .bg_color(bg_color),
`endif
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_last(pix_last),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [SIZE-1:0] mem [DEPTH];
  always @(posedge clk) read_data <= mem[raddr];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [SIZE-1:0] expv(input int k);
    logic [SIZE-1:0] w;
    w = mem[k / HSCALE];
`ifdef PPU_LINE_READER_COLORKEY_EN
    if (w == key_color) w = bg_color;
`endif
    return w;
  endfunction

  // Downstream ready: 0 always, 1 pattern 1,0,0,1, 2 random.
  int rmode = 0;
  int pat = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: pix_ready = 1'b1;
      1: begin
        pix_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
        pat++;
      end
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Behavioural model and compare process.
  int              beat = 0;
  bit              exp_busy = 0;
  bit              done_exp = 0;
  bit              stall_prev = 0;
  bit              last_x;
  logic [SIZE-1:0] prev_data;
  logic [SIZE-1:0] last_beat_data;
  int              lines_done = 0;
  int              bubbles = 0;
  int              xfers = 0;
  int              raddr_max = 0;

  always @(negedge clk) begin
    if (rst) begin
      beat = 0;
      exp_busy = 0;
      done_exp = 0;
      stall_prev = 0;
    end else begin
      chk("busy", busy, exp_busy);
      chk("done", done, done_exp);
      if (!exp_busy) chk("raddr_idle", raddr, 0);
      if (done) lines_done++;
      if (int'(raddr) > raddr_max) raddr_max = int'(raddr);
      if (pix_valid) begin
        if (!exp_busy) chk("valid_idle", pix_valid, 0);
        else begin
          chk("pix_data", pix_data, expv(beat));
          chk("pix_last", pix_last, beat == TOTAL - 1);
        end
        if (stall_prev) chk("stall_stable", pix_data, prev_data);
      end else begin
        if (stall_prev) chk("stall_valid", pix_valid, 1);
        if (exp_busy && beat > 0 && beat < TOTAL) bubbles++;
      end
      last_x = pix_valid && pix_ready && exp_busy && (beat == TOTAL - 1);
      if (pix_valid && pix_ready) begin
        xfers++;
        beat++;
      end
      if (last_x) begin
        last_beat_data = pix_data;
        exp_busy = 0;
        beat = 0;
      end else if (start && !exp_busy) begin
        exp_busy = 1;
      end
      done_exp = last_x;
      stall_prev = pix_valid && !pix_ready;
      prev_data = pix_data;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_lines(input int target);
    int n = 0;
    while (lines_done < target && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("lines_done", lines_done, target);
  endtask

  task automatic wait_beat(input int b);
    int n = 0;
    while (beat < b && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_beat", beat >= b, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_last"}, pix_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int x0;
    int ld;
    rst = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h10 + i);
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic line: latency, literal first/last words, no bubbles.
    rmode = 0;
    bubbles = 0;
    x0 = xfers;
    raddr_max = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    while (!pix_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("latency_edges", edges, 3);
    chk("first_pix", pix_data, 8'h10);
    wait_lines(1);
    chk("basic_beats", xfers - x0, 16);
    chk("basic_last_data", last_beat_data, 8'h17);
    chk("basic_bubbles", bubbles, 0);
    chk("basic_raddr_max", raddr_max, 7);
    chk("basic_raddr_rest", raddr, 0);

    // Backpressure 1,0,0,1.
    rmode = 1;
    pat = 0;
    x0 = xfers;
    pulse_start();
    wait_lines(2);
    chk("bp_beats", xfers - x0, 16);

    // Start while busy is ignored.
    rmode = 0;
    x0 = xfers;
    pulse_start();
    wait_beat(5);
    pulse_start();
    wait_lines(3);
    repeat (12) @(posedge clk);
    #1;
    chk("busy_start_lines", lines_done, 3);
    chk("busy_start_beats", xfers - x0, 16);

    // Asynchronous reset mid-line.
    pulse_start();
    wait_beat(7);
    #3;
    rst = 1'b1;
    #1;
    check_zero_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_no_done", lines_done, 3);
    x0 = xfers;
    pulse_start();
    wait_lines(4);
    chk("after_reset_beats", xfers - x0, 16);
    chk("after_reset_last", last_beat_data, 8'h17);

    // Back-to-back: restart in the done cycle.
    x0 = xfers;
    pulse_start();
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("b2b_done_seen", done, 1);
    chk("b2b_raddr_wrapped", raddr, 0);
    pulse_start();
    wait_lines(6);
    chk("b2b_beats", xfers - x0, 32);

    // Randomized lines: random contents, random backpressure, random gaps.
    rmode = 2;
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
      if (l == 0) mem[3] = 8'h13;
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      ld = lines_done;
      x0 = xfers;
      pulse_start();
      wait_lines(ld + 1);
      chk("rand_beats", xfers - x0, 16);
    end

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ppu_line_reader.md
Name: ppu_line_reader

Overview:
- Downstream consumer of the PPU line-buffer simple dual-port RAM (read port side): walks one scanline of DEPTH entries, absorbs the RAM's 1-cycle read latency, and emits a valid/ready pixel stream toward the video output stage.
- Each stored word is repeated HSCALE beats for horizontal scaling.
- A 2-entry skid FIFO makes the block tolerant to arbitrary backpressure without losing or duplicating words.

Parameters:
- SIZE, 8, pixel word width; must equal the RAM SIZE.
- DEPTH, 256, entries per scanline; must equal the RAM DEPTH; power of two, >= 2.
- HSCALE, 2, output beats per stored word; 1..16.

Ports:
- clk  input  1  system clock; also drives the RAM rclk.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: begin reading a line from address 0.
- busy  output  1  high from the edge that accepts start until the last beat is accepted.
- raddr  output  $clog2(DEPTH)  RAM read address; registered.
- read_data  input  SIZE  RAM read data; valid the cycle after the address is issued.
- pix_data  output  SIZE  output pixel.
- pix_valid  output  1  pix_data valid.
- pix_ready  input  1  downstream accepts; a beat transfers when pix_valid & pix_ready.
- pix_last  output  1  high with the final beat of the line (last word, last repeat).
- done  output  1  one-cycle pulse the cycle after the final beat transfers.

Behaviour:
- Reset values (async, immediate): busy=0, raddr=0, pix_valid=0, pix_last=0, done=0, pix_data=0. FIFO is emptied, the in-flight flag and counters are cleared, state=IDLE.
- States:
  - IDLE: start -> FETCH; addr counter=0, issued=0.
  - FETCH: issue reads until DEPTH issued -> DRAIN.
  - DRAIN: wait until FIFO empty and no read in flight, and final beat transferred -> IDLE, pulse done.
- start is ignored when not in IDLE. No queuing.
- Issue rule:
  - A read issues in a cycle when state=FETCH and (fifo_count + inflight - pop) < 2, where pop is the final-repeat transfer this cycle.
  - On issue: inflight<=1 and raddr<=raddr+1.
  - raddr wraps to 0 after DEPTH-1; the wrap coincides with the FETCH->DRAIN transition. raddr rests at 0 in IDLE.
- Capture: when inflight=1, read_data is written into the FIFO at the following edge. The credit rule guarantees no overflow; a FIFO overflow is a design error and must be assertable in simulation.
- Output:
  - pix_data/pix_valid come from the FIFO head.
  - A repeat counter rep counts 0..HSCALE-1 per head word.
  - On transfer: if rep=HSCALE-1, pop the FIFO and set rep=0; otherwise rep+1.
  - pix_valid=0 -> rep holds; pix_data is stable while pix_valid & !pix_ready.
- pix_last = pix_valid & (rep=HSCALE-1) & (head is word DEPTH-1). Tracked with an output word counter, not with raddr.
- Latency: start sampled at edge E0 -> raddr=0 issued in cycle after E0 -> data captured at E2 -> pix_valid=1 after E2. With pix_ready held high, the line completes DEPTH*HSCALE beats back-to-back with no bubbles (HSCALE>=2). HSCALE=1 also sustains 1 beat/cycle given the 2-entry FIFO.
- Total beats per line is exactly DEPTH*HSCALE. No extra beats after pix_last.
- Reset mid-line aborts immediately: no done pulse; the next start begins at address 0.
- Simultaneous capture and pop in the same cycle: the FIFO count is unchanged and ordering is preserved.

Optional Feature:
- PPU_LINE_READER_COLORKEY_EN defined:
  - Adds input key_color [SIZE] and input bg_color [SIZE].
  - Any head word equal to key_color is emitted as bg_color. Substitution is on the output mux only and adds no latency.
- Undefined: ports absent; words pass through unmodified.

Test Plan:
- Bench config for all scenarios: DEPTH=8, HSCALE=2, RAM preloaded with 0x10..0x17.
- Basic line: start pulse, pix_ready=1 -> first pix_valid 3 edges after start; stream 10,10,11,11,...,17,17 (16 beats, no gaps); pix_last on beat 16 only; done the next cycle; busy falls with it.
- Backpressure: pix_ready toggled 1,0,0,1 repeating -> same 16-beat sequence, no drops or duplicates, pix_data stable while stalled; FIFO count never exceeds 2.
- Start while busy: second start pulse at beat 5 -> ignored; exactly 16 beats; one done pulse.
- Async reset mid-line: assert rst at beat 7 -> outputs zero immediately, no done; a new start produces a full correct line from 0x10.
- Back-to-back lines: start in the cycle done pulses -> second line streams 10..17 correctly; raddr wraps 7->0.
- COLORKEY_EN build: key_color=0x13, bg_color=0xAA -> beats 7-8 read AA,AA; all others unchanged.
